// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - HI/LO multiply/divide unit with a 32-step iterative datapath.
// DIV/DIVU support is compiled in only when MDU_DIV_EN is defined.
module mdu_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] src0_i,
   input  logic [31:0] src1_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        dz_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   state_t      state;
   state_t      state_nx;
   logic [4:0]  cnt;
   logic [63:0] acc;
   logic [31:0] opnd;
   logic        neg_lo;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;
   logic        dz;

   logic        accept;
   logic        long_op;
   logic        div_op;
   logic        sgn_op;
   logic        commit;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] mul_sum;
   logic [63:0] mul_nx;
   logic [63:0] step_nx;
   logic [63:0] prod;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

`ifdef MDU_DIV_EN
   logic        is_div;
   logic        neg_hi;
   logic [31:0] dividend;
   logic [32:0] div_tmp;
   logic [32:0] div_dif;
   logic        div_ge;
   logic [63:0] div_nx;
`endif

   assign busy_o = (state != IDLE);
   assign done_o = done;
   assign dz_o   = dz;
   assign hi_o   = hi;
   assign lo_o   = lo;

   always_comb begin
      accept = valid_i && (state == IDLE) && !flush_i;
      sgn_op = (op_i == OP_MULT) || (op_i == OP_DIV);
`ifdef MDU_DIV_EN
      div_op = (op_i == OP_DIV) || (op_i == OP_DIVU);
`else
      div_op = 1'b0;
`endif
      long_op = (op_i == OP_MULT) || (op_i == OP_MULTU) || div_op;
      a_mag   = (sgn_op && src0_i[31]) ? -src0_i : src0_i;
      b_mag   = (sgn_op && src1_i[31]) ? -src1_i : src1_i;
   end

   always_comb begin
      state_nx = state;
      commit   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept && long_op)
               state_nx = CALC;
         end
         CALC: begin
            if (flush_i)
               state_nx = IDLE;
            else if (cnt == 5'd31)
               state_nx = FIX;
         end
         FIX: begin
            state_nx = IDLE;
            commit   = !flush_i;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Multiply: acc = {partial, multiplier}, shifted right once per step.
   always_comb begin
      mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      mul_nx  = {mul_sum, acc[31:1]};
`ifdef MDU_DIV_EN
      // Divide: acc = {remainder, dividend/quotient}, shifted left once per step.
      div_tmp = {acc[63:32], acc[31]};
      div_ge  = (div_tmp >= {1'b0, opnd});
      div_dif = div_tmp - {1'b0, opnd};
      div_nx  = {(div_ge ? div_dif[31:0] : div_tmp[31:0]), acc[30:0], div_ge};
      step_nx = is_div ? div_nx : mul_nx;
`else
      step_nx = mul_nx;
`endif
   end

   always_comb begin
      prod   = neg_lo ? -acc : acc;
      res_hi = prod[63:32];
      res_lo = prod[31:0];
`ifdef MDU_DIV_EN
      if (is_div) begin
         if (opnd == 32'd0) begin
            res_lo = 32'hFFFF_FFFF;
            res_hi = dividend;
         end else begin
            res_lo = neg_lo ? -acc[31:0]  : acc[31:0];
            res_hi = neg_hi ? -acc[63:32] : acc[63:32];
         end
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt      <= 5'd0;
         acc      <= 64'd0;
         opnd     <= 32'd0;
         neg_lo   <= 1'b0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         done     <= 1'b0;
         dz       <= 1'b0;
`ifdef MDU_DIV_EN
         is_div   <= 1'b0;
         neg_hi   <= 1'b0;
         dividend <= 32'd0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (long_op) begin
                     cnt    <= 5'd0;
                     dz     <= 1'b0;
                     neg_lo <= sgn_op && (src0_i[31] ^ src1_i[31]);
                     if (div_op) begin
                        acc  <= {32'd0, a_mag};
                        opnd <= b_mag;
                     end else begin
                        acc  <= {32'd0, b_mag};
                        opnd <= a_mag;
                     end
`ifdef MDU_DIV_EN
                     is_div   <= div_op;
                     neg_hi   <= sgn_op && src0_i[31];
                     dividend <= src0_i;
`endif
                  end
                  if (op_i == OP_MTHI)
                     hi <= src0_i;
                  if (op_i == OP_MTLO)
                     lo <= src0_i;
               end
            end
            CALC: begin
               if (!flush_i) begin
                  acc <= step_nx;
                  cnt <= cnt + 5'd1;
               end
            end
            FIX: begin
               if (commit) begin
                  hi   <= res_hi;
                  lo   <= res_lo;
                  done <= 1'b1;
`ifdef MDU_DIV_EN
                  dz   <= is_div && (opnd == 32'd0);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - randomized self-checking bench for mdu_ctrl against an arithmetic model.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [2:0]  op;
   logic [31:0] src0;
   logic [31:0] src1;
   logic        flush;
   logic        busy;
   logic        done;
   logic        dz;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] hi_m;
   logic [31:0] lo_m;
   logic        dz_m;

   mdu_ctrl dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid),
      .op_i    (op),
      .src0_i  (src0),
      .src1_i  (src1),
      .flush_i (flush),
      .busy_o  (busy),
      .done_o  (done),
      .dz_o    (dz),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Architectural effect of one accepted op; returns the expected busy length.
   task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
      longint      sa;
      longint      sb;
      longint      sq;
      longint      sr;
      logic [63:0] p;
      logic [63:0] ua;
      logic [63:0] ub;
      sa  = $signed(a);
      sb  = $signed(b);
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      cyc = 0;
      case (o)
         3'd1: begin
            p = sa * sb;
            hi_m = p[63:32]; lo_m = p[31:0]; dz_m = 1'b0; cyc = 33;
         end
         3'd2: begin
            p = ua * ub;
            hi_m = p[63:32]; lo_m = p[31:0]; dz_m = 1'b0; cyc = 33;
         end
`ifdef MDU_DIV_EN
         3'd3: begin
            cyc = 33;
            if (b == 32'd0) begin
               lo_m = 32'hFFFF_FFFF; hi_m = a; dz_m = 1'b1;
            end else begin
               sq = sa / sb; sr = sa % sb;
               lo_m = sq[31:0]; hi_m = sr[31:0]; dz_m = 1'b0;
            end
         end
         3'd4: begin
            cyc = 33;
            if (b == 32'd0) begin
               lo_m = 32'hFFFF_FFFF; hi_m = a; dz_m = 1'b1;
            end else begin
               p = ua / ub; lo_m = p[31:0];
               p = ua % ub; hi_m = p[31:0]; dz_m = 1'b0;
            end
         end
`endif
         3'd5: hi_m = a;
         3'd6: lo_m = a;
         default: ;
      endcase
   endtask

   // Called at a negedge; returns at the negedge where busy has dropped.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit junk, input string tag);
      int cyc_exp;
      int cyc;
      model(o, a, b, cyc_exp);
      valid = 1'b1; op = o; src0 = a; src1 = b;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         if (junk) begin
            valid = 1'b1;
            op    = 3'($urandom_range(1, 6));
            src0  = $urandom;
            src1  = $urandom;
         end
         @(negedge clk);
      end
      valid = 1'b0;
      check({tag, " busy_len"}, cyc, cyc_exp);
      check({tag, " done"}, done, cyc_exp != 0);
      check({tag, " hi"}, hi, hi_m);
      check({tag, " lo"}, lo, lo_m);
      check({tag, " dz"}, dz, dz_m);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;
      rst = 1'b1; valid = 1'b0; flush = 1'b0; op = 3'd0; src0 = 32'd0; src1 = 32'd0;
      hi_m = 32'd0; lo_m = 32'd0; dz_m = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset dz", dz, 1'b0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      rst = 1'b0;

      run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, "mult_neg");
      check("mult_neg hi_const", hi, 32'hFFFF_FFFF);
      check("mult_neg lo_const", lo, 32'hFFFF_FFFA);
      @(negedge clk);
      check("done single pulse", done, 1'b0);

      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
      check("multu_max hi_const", hi, 32'hFFFF_FFFE);
      check("multu_max lo_const", lo, 32'h0000_0001);

`ifdef MDU_DIV_EN
      run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_neg");
      check("div_neg lo_const", lo, 32'hFFFF_FFFD);
      check("div_neg hi_const", hi, 32'hFFFF_FFFF);
      run_op(3'd4, 32'h0000_0007, 32'h0000_0000, 1'b0, "divu_zero");
      check("divu_zero dz_const", dz, 1'b1);
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
      check("div_ovf lo_const", lo, 32'h8000_0000);
      check("div_ovf hi_const", hi, 32'h0000_0000);
`else
      run_op(3'd3, 32'h0000_0008, 32'h0000_0002, 1'b0, "div_off");
      run_op(3'd4, 32'h0000_0009, 32'h0000_0000, 1'b0, "divu_off");
`endif

      run_op(3'd5, 32'h1234_5678, 32'h0, 1'b0, "mthi");
      check("mthi hi_const", hi, 32'h1234_5678);

      // Flush partway through CALC.
      valid = 1'b1; op = 3'd1; src0 = 32'd5; src1 = 32'd5;
      @(posedge clk); @(negedge clk);
      valid = 1'b0;
      repeat (9) @(negedge clk);
      check("flush_calc busy_before", busy, 1'b1);
      flush = 1'b1;
      @(posedge clk); #1;
      check("flush_calc busy_after", busy, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      check("flush_calc done", done, 1'b0);
      check("flush_calc hi", hi, hi_m);
      check("flush_calc lo", lo, lo_m);
      check("flush_calc dz", dz, dz_m);
      run_op(3'd6, 32'h0000_ABCD, 32'h0, 1'b0, "mtlo_after_flush");
      check("mtlo lo_const", lo, 32'h0000_ABCD);

      // Flush landing in the FIX cycle.
      valid = 1'b1; op = 3'd2; src0 = 32'h0001_0000; src1 = 32'h0001_0000;
      @(posedge clk); @(negedge clk);
      valid = 1'b0;
      repeat (32) @(negedge clk);
      check("flush_fix busy_before", busy, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_fix busy_after", busy, 1'b0);
      check("flush_fix done", done, 1'b0);
      check("flush_fix hi", hi, hi_m);
      check("flush_fix lo", lo, lo_m);

      // Flush beats valid in IDLE.
      valid = 1'b1; op = 3'd5; src0 = 32'hDEAD_BEEF; flush = 1'b1;
      @(posedge clk); @(negedge clk);
      op = 3'd1;
      @(posedge clk); @(negedge clk);
      valid = 1'b0; flush = 1'b0;
      check("flush_idle busy", busy, 1'b0);
      check("flush_idle hi", hi, hi_m);

      run_op(3'd1, $urandom, $urandom, 1'b1, "ignore_while_busy");

      for (int i = 0; i < 60; i++) begin
         r_op = 3'($urandom_range(0, 7));
         r_a  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         r_b  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         run_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)), $sformatf("rand%0d op%0d", i, r_op));
      end

      // Reset while calculating.
      valid = 1'b1; op = 3'd2; src0 = $urandom; src1 = $urandom;
      @(posedge clk); @(negedge clk);
      valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      hi_m = 32'd0; lo_m = 32'd0; dz_m = 1'b0;
      check("midreset busy", busy, 1'b0);
      check("midreset done", done, 1'b0);
      check("midreset dz", dz, 1'b0);
      check("midreset hi", hi, 32'd0);
      check("midreset lo", lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
